// File: rtl/seg_red_unit_if.sv
// -----------------------------------------------------------------------------
// seg_red_unit_if
//   Beat-level bus of the segmented reduction unit.
//
//   Handshake: a beat is transferred on every rising clock edge at which
//   in_valid=1 and there is no ready signal, so the unit accepts every beat.
//   out_valid=1 marks the single cycle in which out_data carries one result.
//   The consumer has no backpressure and must take every out_valid beat.
//
//   Signals:
//     in_valid  beat present on data/split/out_idx
//     data      N lanes of W-bit operands
//     split     split[i]=1 marks lane i as the last lane of its segment
//     out_idx   per output lane, the source lane whose running sum is output
//     out_valid out_data holds a result this cycle
//     out_data  N lanes of selected segmented running sums
//
//   Modports: master = beat producer / result consumer, slave = the unit.
// -----------------------------------------------------------------------------
interface seg_red_unit_if #(
    parameter int N   = 16,
    parameter int W   = 8,
    parameter int LGN = $clog2(N)
);
    logic                  in_valid;
    logic [N-1:0][W-1:0]   data;
    logic [N-1:0]          split;
    logic [N-1:0][LGN-1:0] out_idx;
    logic                  out_valid;
    logic [N-1:0][W-1:0]   out_data;

    modport master (
        output in_valid, data, split, out_idx,
        input  out_valid, out_data
    );

    modport slave (
        input  in_valid, data, split, out_idx,
        output out_valid, out_data
    );
endinterface

// File: rtl/seg_red_unit.sv
// -----------------------------------------------------------------------------
// seg_red_unit
//   Fully pipelined segmented reduction: LGN registered Hillis-Steele scan
//   stages (distances 1,2,4,...,N/2) followed by one output register that
//   selects, per output lane, the segment-running sum of lane out_idx[i].
//   Sums wrap modulo 2^W. Latency LGN+1 cycles, one beat per cycle.
//
//   Ports:
//     clock   rising-edge clock
//     reset   asynchronous active-low reset
//     bus     seg_red_unit_if.slave (in_valid/data/split/out_idx in,
//             out_valid/out_data out)
//     delay   constant LGN+1
//     num_el  constant N
//
//   Build option SEG_CARRY_EN: when defined, the trailing running sum of a
//   beat with split[N-1]=0 is carried into the leading segment of the next
//   valid beat (a row spanning beats). When undefined, beats are independent
//   and split[N-1] is ignored.
// -----------------------------------------------------------------------------
module seg_red_unit #(
    parameter int N   = 16,
    parameter int W   = 8,
    parameter int LGN = $clog2(N)
) (
    input  logic          clock,
    input  logic          reset,
    seg_red_unit_if.slave bus,
    output int            delay,
    output int            num_el
);
    typedef logic [N-1:0][W-1:0]   vec_t;
    typedef logic [N-1:0][LGN-1:0] idx_t;

    assign delay  = LGN + 1;
    assign num_el = N;

    // Index 0 is the incoming beat, index k+1 is the register of stage k.
    logic [LGN:0][N-1:0][W-1:0]   w_v;
    logic [LGN:0][N-1:0]          w_f;
    logic [LGN:0][N-1:0][LGN-1:0] w_idx;
    logic [LGN:0]                 w_vld;

    // Segment start flags: lane 0 always starts a segment.
    assign w_v[0]   = bus.data;
    assign w_f[0]   = {bus.split[N-2:0], 1'b1};
    assign w_idx[0] = bus.out_idx;
    assign w_vld[0] = bus.in_valid;

`ifdef SEG_CARRY_EN
    // Side info travelling with each beat: bit N = split[N-1],
    // bits N-1:0 = lane belongs to the segment that starts at lane 0.
    logic [LGN:0][N:0] w_x;
    logic [N:0]        w_x0;

    always_comb begin
        w_x0    = '0;
        w_x0[0] = 1'b1;
        for (int i = 1; i < N; i++) begin
            w_x0[i] = w_x0[i-1] & ~bus.split[i-1];
        end
        w_x0[N] = bus.split[N-1];
    end
    assign w_x[0] = w_x0;
`endif

    for (genvar k = 0; k < LGN; k++) begin : g_stage
        localparam int D = 1 << k;

        vec_t         w_nv;
        logic [N-1:0] w_nf;
        vec_t         r_v;
        logic [N-1:0] r_f;
        idx_t         r_idx;
        logic         r_vld;

        // A lane still inside its segment (flag=0) absorbs the partial sum
        // D lanes below and inherits that lane's flag.
        always_comb begin
            w_nv = w_v[k];
            w_nf = w_f[k];
            for (int i = D; i < N; i++) begin
                if (!w_f[k][i]) begin
                    w_nv[i] = w_v[k][i] + w_v[k][i-D];
                    w_nf[i] = w_f[k][i-D];
                end
            end
        end

        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                r_vld <= 1'b0;
                r_v   <= '0;
                r_f   <= '0;
                r_idx <= '0;
            end else begin
                r_vld <= w_vld[k];
                if (w_vld[k]) begin
                    r_v   <= w_nv;
                    r_f   <= w_nf;
                    r_idx <= w_idx[k];
                end
            end
        end

        assign w_v[k+1]   = r_v;
        assign w_f[k+1]   = r_f;
        assign w_idx[k+1] = r_idx;
        assign w_vld[k+1] = r_vld;

`ifdef SEG_CARRY_EN
        logic [N:0] r_x;
        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                r_x <= '0;
            end else if (w_vld[k]) begin
                r_x <= w_x[k];
            end
        end
        assign w_x[k+1] = r_x;
`endif
    end

    // Output stage.
    vec_t w_r;
    vec_t r_out_data;
    logic r_out_valid;

`ifdef SEG_CARRY_EN
    logic [W-1:0] r_carry;
    logic         r_carry_vld;
`endif

    always_comb begin
        w_r = w_v[LGN];
`ifdef SEG_CARRY_EN
        if (r_carry_vld) begin
            for (int i = 0; i < N; i++) begin
                if (w_x[LGN][i]) begin
                    w_r[i] = w_v[LGN][i] + r_carry;
                end
            end
        end
`endif
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else begin
            r_out_valid <= w_vld[LGN];
            if (w_vld[LGN]) begin
                for (int i = 0; i < N; i++) begin
                    r_out_data[i] <= w_r[w_idx[LGN][i]];
                end
            end
        end
    end

`ifdef SEG_CARRY_EN
    // Carry follows only beats leaving the output stage; the stored sum
    // already includes any carry it absorbed, so a row can span many beats.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_carry     <= '0;
            r_carry_vld <= 1'b0;
        end else if (w_vld[LGN]) begin
            if (!w_x[LGN][N]) begin
                r_carry     <= w_r[N-1];
                r_carry_vld <= 1'b1;
            end else begin
                r_carry_vld <= 1'b0;
            end
        end
    end

    logic w_unused;
    assign w_unused = ^w_f[LGN];
`else
    // Final flags and split[N-1] carry no information without the carry path.
    logic w_unused;
    assign w_unused = ^{w_f[LGN], bus.split[N-1]};
`endif

    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
endmodule

// File: tb/tb_seg_red_unit.sv
module tb_seg_red_unit;
  localparam int N   = 16;
  localparam int W   = 8;
  localparam int LGN = $clog2(N);

  typedef logic [N-1:0][W-1:0]   vec_t;
  typedef logic [N-1:0][LGN-1:0] idx_t;

  logic clock;
  logic reset;
  int   delay;
  int   num_el;

  seg_red_unit_if #(.N(N), .W(W), .LGN(LGN)) bus ();

  seg_red_unit #(.N(N), .W(W), .LGN(LGN)) dut (
    .clock  (clock),
    .reset  (reset),
    .bus    (bus),
    .delay  (delay),
    .num_el (num_el)
  );

  // clock / reset
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // scoreboard state
  vec_t exp_q[$];
  int   iss_q[$];
  int   n_vec = 0;
  int   n_bad = 0;

`ifdef SEG_CARRY_EN
  logic [W-1:0] m_carry = '0;
  logic         m_cvld  = 1'b0;
`endif

  // Reference: for each lane walk back to its segment start and add up.
  task automatic model(input vec_t d, input logic [N-1:0] s, input idx_t ix, output vec_t o);
    logic [W-1:0] r [N];
    logic [W-1:0] acc;
    int st;
    for (int k = 0; k < N; k++) begin
      st = k;
      while (st > 0 && !s[st-1]) st--;
      acc = '0;
      for (int j = st; j <= k; j++) acc = acc + d[j];
`ifdef SEG_CARRY_EN
      if (st == 0 && m_cvld) acc = acc + m_carry;
`endif
      r[k] = acc;
    end
    for (int i = 0; i < N; i++) o[i] = r[ix[i]];
`ifdef SEG_CARRY_EN
    if (!s[N-1]) begin
      m_carry = r[N-1];
      m_cvld  = 1'b1;
    end else begin
      m_cvld = 1'b0;
    end
`endif
  endtask

  // driver tasks
  task automatic send(input vec_t d, input logic [N-1:0] s, input idx_t ix,
                      input bit directed, input vec_t dexp);
    vec_t m;
    model(d, s, ix, m);
    @(negedge clock);
    bus.in_valid = 1'b1;
    bus.data     = d;
    bus.split    = s;
    bus.out_idx  = ix;
    exp_q.push_back(directed ? dexp : m);
    iss_q.push_back(cyc);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      bus.in_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 4 * (LGN + 1)) begin
      @(negedge clock);
      bus.in_valid = 1'b0;
      t++;
    end
    n_vec++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain_timeout: %0d beats outstanding, required 0", exp_q.size());
    end
  endtask

  task automatic check_int(input string name, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic check_idle_zero(input string name);
    n_vec++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== '0) begin
      n_bad++;
      $display("FAIL %s: out_valid=%b out_data=%h, required 0 / 0", name, bus.out_valid, bus.out_data);
    end
  endtask

  function automatic vec_t rand_vec();
    vec_t v;
    for (int i = 0; i < N; i++) v[i] = W'($urandom_range(0, (1 << W) - 1));
    return v;
  endfunction

  function automatic idx_t rand_idx();
    idx_t v;
    for (int i = 0; i < N; i++) v[i] = LGN'($urandom_range(0, N - 1));
    return v;
  endfunction

  function automatic logic [N-1:0] rand_split();
    case ($urandom_range(0, 3))
      0: return '0;
      1: return '1;
      2: return N'($urandom);
      default: return N'($urandom & $urandom & $urandom);
    endcase
  endfunction

  // monitor: pops one expectation per out_valid cycle
  always @(negedge clock) begin
    vec_t e;
    int ic;
    if (reset && bus.out_valid) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL spurious_out: out_valid=1 out_data=%h, required no output", bus.out_data);
      end else begin
        e  = exp_q.pop_front();
        ic = iss_q.pop_front();
        if (bus.out_data !== e) begin
          n_bad++;
          $display("FAIL out_data: got %h, required %h", bus.out_data, e);
        end
        n_vec++;
        if (cyc - ic != LGN + 1) begin
          n_bad++;
          $display("FAIL latency: got %0d, required %0d", cyc - ic, LGN + 1);
        end
      end
    end
  end

  // stimulus
  initial begin
    vec_t d, dexp;
    idx_t ix;
    logic [N-1:0] s;

    reset        = 1'b0;
    bus.in_valid = 1'b0;
    bus.data     = '0;
    bus.split    = '0;
    bus.out_idx  = '0;
    repeat (3) @(posedge clock);
    #1;
    check_idle_zero("reset_state");
    check_int("delay", delay, LGN + 1);
    check_int("num_el", num_el, N);
    @(negedge clock);
    reset = 1'b1;

    // whole-beat sum: 1+2+...+16 = 136 in every lane
    for (int i = 0; i < N; i++) begin
      d[i] = W'(i + 1);
      ix[i] = LGN'(N - 1);
      dexp[i] = 8'd136;
    end
    send(d, '0, ix, 1'b1, dexp);
    idle(1);
    drain();
    send(rand_vec(), '1, rand_idx(), 1'b0, '0);   // closes the row

    // two segments: lanes 0..5 and 6..15, all data 3
    s = '0;
    s[5] = 1'b1;
    s[15] = 1'b1;
    for (int i = 0; i < N; i++) begin
      d[i] = 8'd3;
      ix[i] = '0;
      dexp[i] = 8'd3;
    end
    ix[0] = LGN'(5);
    ix[1] = LGN'(15);
    dexp[0] = 8'd18;
    dexp[1] = 8'd30;
    send(d, s, ix, 1'b1, dexp);

    // wrap: all 0xFF, one segment, lane i reads lane i
    for (int i = 0; i < N; i++) begin
      d[i] = 8'hFF;
      ix[i] = LGN'(i);
      dexp[i] = W'(((i + 1) * 255) % 256);
    end
    send(d, '0, ix, 1'b1, dexp);
    send(rand_vec(), '1, rand_idx(), 1'b0, '0);

    // streaming: 8 back-to-back beats with distinct split patterns
    for (int b = 0; b < 8; b++) begin
      s = N'($urandom) ^ N'(b * 16'h1111);
      s[N-1] = b[0];
      send(rand_vec(), s, rand_idx(), 1'b0, '0);
    end
    send(rand_vec(), '1, rand_idx(), 1'b0, '0);
    idle(1);
    drain();

    // carry across beats
    for (int i = 0; i < N; i++) begin
      d[i] = 8'd1;
      ix[i] = LGN'(3);
      dexp[i] = 8'd4;
    end
    send(d, '0, ix, 1'b1, dexp);                   // A
    s = '0;
    s[3] = 1'b1;
    s[15] = 1'b1;
`ifdef SEG_CARRY_EN
    for (int i = 0; i < N; i++) dexp[i] = 8'd20;
`endif
    send(d, s, ix, 1'b1, dexp);                    // B
    for (int i = 0; i < N; i++) dexp[i] = 8'd4;
    s[15] = 1'b0;
    send(d, s, ix, 1'b1, dexp);                    // C
    idle(2);
    drain();

    // random stream with gaps
    for (int b = 0; b < 150; b++) begin
      send(rand_vec(), rand_split(), rand_idx(), 1'b0, '0);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    for (int i = 0; i < N; i++) d[i] = W'(i + 1);
    send(d, '0, '1, 1'b1, '{default: 8'd136});     // leaves a non-zero out_data
    idle(1);
    drain();

    // reset mid-stream
    send(rand_vec(), rand_split(), rand_idx(), 1'b0, '0);
    send(rand_vec(), rand_split(), rand_idx(), 1'b0, '0);
    send(rand_vec(), rand_split(), rand_idx(), 1'b0, '0);
    @(posedge clock);
    #2;
    reset = 1'b0;
    exp_q.delete();
    iss_q.delete();
`ifdef SEG_CARRY_EN
    m_cvld = 1'b0;
`endif
    #1;
    check_idle_zero("reset_midstream");
    @(negedge clock);
    bus.in_valid = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    idle(12);
    check_idle_zero("post_reset_quiet");

    // fresh beat after reset
    send(rand_vec(), rand_split(), rand_idx(), 1'b0, '0);
    idle(1);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
